// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Drains bytes from a single-byte UART receive buffer into a
//                first-word-fall-through FIFO, storing each byte together
//                with its {PERR,FERR,OVF} flags and acknowledging it to the
//                receive block with a one-cycle READ pulse.
//  Ports       :
//    clk      - system clock, rising edge
//    reset    - asynchronous active-low reset
//    RX_RDY   - receive block holds an unread byte
//    RX_DATA  - received byte
//    PERR/FERR/OVF - error flags belonging to RX_DATA
//    READ     - one-cycle acknowledge back to the receive block
//    POP      - host consumes the head entry
//    DOUT     - head data byte (0 when EMPTY)
//    DERR     - head flags {PERR,FERR,OVF} (0 when EMPTY)
//    EMPTY    - FIFO holds no entries
//    FULL     - FIFO holds DEPTH entries
//    COUNT    - number of occupied entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RX_RDY,
    input  logic [7:0]    RX_DATA,
    input  logic          PERR,
    input  logic          FERR,
    input  logic          OVF,
    output logic          READ,
    input  logic          POP,
    output logic [7:0]    DOUT,
    output logic [2:0]    DERR,
    output logic          EMPTY,
    output logic          FULL,
    output logic [AW:0]   COUNT
);

    localparam logic [AW:0]   c_full_count = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_count_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_read;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [10:0]     r_mem [DEPTH];

    logic            w_write;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [10:0]     w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);

    // FULL is the pre-pop value, so a byte arriving while full waits one
    // extra cycle even if the host pops on the same edge.
    assign w_write = (r_state == ST_IDLE) && RX_RDY && !w_full;
    assign w_pop   = POP && !w_empty;

    // Storage is intentionally not reset; the reset term only keeps a byte
    // presented during reset from being written behind the pointers' back.
    always_ff @(posedge clk) begin
        if (w_write && reset) begin
            r_mem[r_wptr] <= {PERR, FERR, OVF, RX_DATA};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_read  <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_read <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_write) begin
                        r_read  <= 1'b1;
                        r_wptr  <= r_wptr + c_ptr_one;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Hold off until the receive block has dropped RX_RDY so
                    // the same byte cannot be captured twice.
                    if (!RX_RDY) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end

            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = r_mem[r_rptr];

    assign READ  = r_read;
    assign DOUT  = w_empty ? 8'h00 : w_head[7:0];
    assign DERR  = w_empty ? 3'b000 : w_head[10:8];
    assign EMPTY = w_empty;
    assign FULL  = w_full;
    assign COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Scoreboard bench for uart_rx_fifo. Stimulus tasks play the
//                receive block and push each accepted byte's expected entry;
//                a monitor compares the head whenever the host pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic        clk;
    logic        reset;
    logic        RX_RDY;
    logic [7:0]  RX_DATA;
    logic        PERR;
    logic        FERR;
    logic        OVF;
    logic        READ;
    logic        POP;
    logic [7:0]  DOUT;
    logic [2:0]  DERR;
    logic        EMPTY;
    logic        FULL;
    logic [4:0]  COUNT;

    int n_vec;
    int n_err;
    int read_pulses;
    logic [10:0] sb [$];

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .RX_RDY  (RX_RDY),
        .RX_DATA (RX_DATA),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF),
        .READ    (READ),
        .POP     (POP),
        .DOUT    (DOUT),
        .DERR    (DERR),
        .EMPTY   (EMPTY),
        .FULL    (FULL),
        .COUNT   (COUNT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change on the falling edge, so 1 time unit later
    // everything the next rising edge will see is stable.
    always begin
        logic [10:0] exp_entry;
        @(negedge clk);
        #1;
        if (READ) read_pulses++;
        if (reset && POP) begin
            if (!EMPTY) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_entry = sb.pop_front();
                    chk("head_entry", 32'({DERR, DOUT}), 32'(exp_entry));
                end
            end else begin
                chk("empty_pop_dout", 32'({DERR, DOUT}), 32'd0);
            end
        end
    end

    // Present a byte as the receive block would, wait for READ, then keep
    // RX_RDY high for 'hold' further cycles before clearing it.
    task automatic send_byte(input logic [7:0] d, input logic [2:0] f, input int hold);
        bit seen;
        @(negedge clk);
        RX_RDY  = 1'b1;
        RX_DATA = d;
        {PERR, FERR, OVF} = f;
        sb.push_back({f, d});
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (READ) seen = 1'b1;
        end
        chk("read_ack", 32'(seen), 32'd1);
        repeat (hold) @(negedge clk);
        RX_RDY = 1'b0;
    endtask

    task automatic pop_n(input int n);
        repeat (n) begin
            @(negedge clk);
            POP = 1'b1;
        end
        @(negedge clk);
        POP = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  snap;
        bit  seen;
        n_vec = 0;
        n_err = 0;
        read_pulses = 0;
        reset   = 1'b0;
        RX_RDY  = 1'b0;
        RX_DATA = 8'h00;
        PERR = 1'b0; FERR = 1'b0; OVF = 1'b0;
        POP = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_read",  32'(READ),  32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_full",  32'(FULL),  32'd0);
        chk("rst_dout",  32'(DOUT),  32'd0);
        chk("rst_derr",  32'(DERR),  32'd0);
        reset = 1'b1;

        // 1. Asynchronous reset while READ is high / FSM in WAIT
        @(negedge clk);
        RX_RDY = 1'b1; RX_DATA = 8'h5A;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (READ) seen = 1'b1;
        end
        chk("t1_read_ack", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t1_read",  32'(READ),  32'd0);
        chk("t1_count", 32'(COUNT), 32'd0);
        chk("t1_empty", 32'(EMPTY), 32'd1);
        chk("t1_dout",  32'(DOUT),  32'd0);
        RX_RDY = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        snap = read_pulses;
        repeat (4) @(negedge clk);
        chk("t1_no_write", 32'(COUNT), 32'd0);
        chk("t1_no_read",  32'(read_pulses - snap), 32'd0);

        // 2. Single byte A5
        snap = read_pulses;
        send_byte(8'hA5, 3'b000, 0);
        @(negedge clk);
        chk("t2_pulses", 32'(read_pulses - snap), 32'd1);
        chk("t2_count",  32'(COUNT), 32'd1);
        chk("t2_dout",   32'(DOUT),  32'hA5);
        chk("t2_derr",   32'(DERR),  32'd0);
        pop_n(1);
        chk("t2_empty",  32'(EMPTY), 32'd1);
        chk("t2_dout0",  32'(DOUT),  32'd0);

        // 3. RX_RDY held 5 cycles after READ
        snap = read_pulses;
        send_byte(8'h77, 3'b001, 5);
        @(negedge clk);
        chk("t3_count",  32'(COUNT), 32'd1);
        chk("t3_pulses", 32'(read_pulses - snap), 32'd1);
        pop_n(1);

        // 4. Fill, stall on full, resume after one pop
        for (int i = 0; i < 16; i++) send_byte(8'(i), 3'b000, 0);
        @(negedge clk);
        chk("t4_full",  32'(FULL),  32'd1);
        chk("t4_count", 32'(COUNT), 32'd16);
        snap = read_pulses;
        RX_RDY = 1'b1; RX_DATA = 8'hA7; {PERR, FERR, OVF} = 3'b001;
        sb.push_back({3'b001, 8'hA7});
        repeat (4) @(negedge clk);
        chk("t4_stall_read",  32'(read_pulses - snap), 32'd0);
        chk("t4_stall_count", 32'(COUNT), 32'd16);
        POP = 1'b1;
        @(negedge clk);
        POP = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (READ) seen = 1'b1;
        end
        chk("t4_resume", 32'(seen), 32'd1);
        RX_RDY = 1'b0;
        chk("t4_count_after", 32'(COUNT), 32'd16);
        pop_n(16);
        chk("t4_empty", 32'(EMPTY), 32'd1);

        // 5. Error flags travel with their byte
        send_byte(8'h3C, 3'b110, 0);
        @(negedge clk);
        chk("t5_dout", 32'(DOUT), 32'h3C);
        chk("t5_derr", 32'(DERR), 32'b110);
        send_byte(8'h3D, 3'b000, 0);
        pop_n(1);
        chk("t5_dout2", 32'(DOUT), 32'h3D);
        chk("t5_derr2", 32'(DERR), 32'b000);
        pop_n(1);

        // 6. Simultaneous write and pop at COUNT=3, then wrap traffic
        send_byte(8'h61, 3'b000, 0);
        send_byte(8'h62, 3'b010, 0);
        send_byte(8'h63, 3'b100, 0);
        @(negedge clk);
        chk("t6_count3", 32'(COUNT), 32'd3);
        RX_RDY = 1'b1; RX_DATA = 8'h64; {PERR, FERR, OVF} = 3'b011;
        sb.push_back({3'b011, 8'h64});
        POP = 1'b1;
        @(negedge clk);
        POP = 1'b0;
        chk("t6_same_read",  32'(READ),  32'd1);
        chk("t6_same_count", 32'(COUNT), 32'd3);
        RX_RDY = 1'b0;
        pop_n(3);
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(64 + i), 3'(i % 8), 0);
            if (i % 3 == 2) pop_n(2);
        end
        pop_n(16);
        chk("t6_count0", 32'(COUNT), 32'd0);
        chk("t6_empty",  32'(EMPTY), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
